div: RTL and testbench

Sequential shift-subtract (restoring) unsigned divider. It is the inverse companion to the team's sequential multiplier and shares its board-level hookup style: the dividend and divisor come from rotary switches, load comes from a push-switch function, and the results go to the 7-segment display. It produces one quotient bit per clock, so the result is ready DW clocks after load is released. A status flag reports divide-by-zero.

---
 rtl/div_if.sv | 19 +
 rtl/div.sv | 81 ++++++++
 tb/tb_div.sv | 137 +++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Operand/result bundle for the sequential divider: switches drive a, b and ld,
// the display side reads the working registers and status flags.
interface div_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          ld;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic [DW-1:0] rq;
  logic [VW-1:0] rr;
  logic [VW-1:0] rb;
  logic          busy;
  logic          done;
  logic          dz;

  modport master (output ld, a, b, input rq, rr, rb, busy, done, dz);
  modport slave  (input ld, a, b, output rq, rr, rb, busy, done, dz);
endinterface

// File: rtl/div.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// ld is a level load/abort; rq shifts the dividend out while quotient bits shift in.
module div #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int CW = (DW > 2) ? $clog2(DW) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rq, rq_n;
  logic [VW-1:0] rr, rr_n, rb, diff;
  logic [VW:0]   t;
  logic          dz, ge;

  // rr < rb always holds, so t - rb fits in VW bits and the low-bit subtract is exact
  always_comb begin
    t    = {rr, rq[DW-1]};
    ge   = (t >= {1'b0, rb});
    diff = t[VW-1:0] - rb;
    rq_n = {rq[DW-2:0], ge};
    rr_n = ge ? diff : t[VW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rq    <= '0;
      rr    <= '0;
      rb    <= '0;
      dz    <= 1'b0;
    end else if (bus.ld) begin
      state <= LOAD;
      cnt   <= '0;
      rq    <= bus.a;
      rr    <= '0;
      rb    <= bus.b;
      dz    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (rb == '0) begin
            rr    <= rq[VW-1:0];
            rq    <= '1;
            dz    <= 1'b1;
            state <= DONE;
          end else begin
            rq    <= rq_n;
            rr    <= rr_n;
            cnt   <= CW'(1);
            state <= RUN;
          end
        end
        RUN: begin
          rq <= rq_n;
          rr <= rr_n;
          if (cnt == CW'(DW - 1)) state <= DONE;
          else                    cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rq   = rq;
  assign bus.rr   = rr;
  assign bus.rb   = rb;
  assign bus.dz   = dz;
  assign bus.busy = (state == LOAD) || (state == RUN);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_div.sv
// Directed bench for div: hand-computed quotients/remainders, divide-by-zero,
// abort, async reset and a full 8/4-bit identity sweep.
module tb_div;
  localparam int DW = 8;
  localparam int VW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  div_if #(.DW(DW), .VW(VW)) bus ();
  div #(.DW(DW), .VW(VW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // pulse ld for one edge, then run DW edges checking busy/done on each
  task automatic do_div(input int av, input int bv, input int q, input int r, input bit hard);
    bus.ld = 1'b1; bus.a = DW'(av); bus.b = VW'(bv);
    tick();
    bus.ld = 1'b0;
    if (hard) begin
      chk("load_busy", 32'(bus.busy), 1);
      chk("load_rb", 32'(bus.rb), 32'(bv));
      chk("load_dz", 32'(bus.dz), 0);
    end
    for (int k = 1; k <= DW; k++) begin
      tick();
      if (k < DW) begin
        if (hard) chk($sformatf("busy_e%0d", k), 32'(bus.busy), 1);
        chk($sformatf("nodone_e%0d", k), 32'(bus.done), 0);
      end
    end
    chk("done", 32'(bus.done), 1);
    chk("busy_end", 32'(bus.busy), 0);
    chk("dz_end", 32'(bus.dz), 0);
    if (hard) begin
      chk($sformatf("rq_%0d_%0d", av, bv), 32'(bus.rq), 32'(q));
      chk($sformatf("rr_%0d_%0d", av, bv), 32'(bus.rr), 32'(r));
    end else begin
      chk($sformatf("id_%0d_%0d", av, bv), 32'(bus.rq) * 32'(bv) + 32'(bus.rr), 32'(av));
      chk($sformatf("rem_%0d_%0d", av, bv), 32'(32'(bus.rr) < 32'(bv)), 1);
    end
  endtask

  initial begin
    bus.ld = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    chk("rst_rq", 32'(bus.rq), 0);
    chk("rst_rr", 32'(bus.rr), 0);
    chk("rst_rb", 32'(bus.rb), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_dz", 32'(bus.dz), 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(bus.busy), 0);

    do_div(200, 7, 28, 4, 1'b1);
    tick(); tick();
    chk("hold_rq", 32'(bus.rq), 28);
    chk("hold_rr", 32'(bus.rr), 4);
    chk("hold_done", 32'(bus.done), 1);
    do_div(255, 1, 255, 0, 1'b1);
    do_div(255, 15, 17, 0, 1'b1);
    do_div(5, 9, 0, 5, 1'b1);

    // divide by zero finishes after one edge
    bus.ld = 1'b1; bus.a = 8'd100; bus.b = 4'd0;
    tick();
    bus.ld = 1'b0;
    tick();
    chk("dz_done", 32'(bus.done), 1);
    chk("dz_flag", 32'(bus.dz), 1);
    chk("dz_busy", 32'(bus.busy), 0);
    chk("dz_rq", 32'(bus.rq), 255);
    chk("dz_rr", 32'(bus.rr), 4);
    do_div(100, 3, 33, 1, 1'b1);

    // ld held high keeps recapturing operands
    bus.ld = 1'b1; bus.a = 8'd10; bus.b = 4'd3;
    tick();
    chk("ldhold_rq0", 32'(bus.rq), 10);
    bus.a = 8'd20; bus.b = 4'd5;
    tick();
    chk("ldhold_rq1", 32'(bus.rq), 20);
    chk("ldhold_rb1", 32'(bus.rb), 5);
    chk("ldhold_busy", 32'(bus.busy), 1);

    // abort mid-run and restart with new operands
    bus.a = 8'd200; bus.b = 4'd7;
    tick();
    bus.ld = 1'b0;
    tick(); tick(); tick();
    chk("abort_busy", 32'(bus.busy), 1);
    do_div(50, 6, 8, 2, 1'b1);

    // asynchronous reset between edges during RUN
    bus.ld = 1'b1; bus.a = 8'd200; bus.b = 4'd7;
    tick();
    bus.ld = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_rq", 32'(bus.rq), 0);
    chk("arst_rr", 32'(bus.rr), 0);
    chk("arst_rb", 32'(bus.rb), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_dz", 32'(bus.dz), 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_done", 32'(bus.done), 0);
    chk("post_rst_rq", 32'(bus.rq), 0);

    for (int av = 0; av < 256; av++)
      for (int bv = 1; bv < 16; bv++)
        do_div(av, bv, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
